uart_rx: RTL and testbench

Serial receiver for the UART path: oversamples the `rx` pin on the 16x sampling tick produced by the baud generator and assembles LSB-first frames into parallel bytes. It sits directly downstream of the baud generator's `tick` output and upstream of the RX FIFO and bus interface. Each received frame produces a one-cycle strobe with the data word and a frame-error flag.

---
 rtl/uart_pkg.sv | 9 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int START_MID  = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous input pins, with a selectable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first frames into parallel words with
// a one-cycle done strobe and stop-bit error flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  // Tick counter must reach both 15 (data bits) and SB_TICK-1 (stop bit).
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = ($clog2(DBIT) > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID      = SW'(START_MID);
  localparam logic [SW-1:0] S_BIT_END  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

  rx_state_t       state, state_next;
  logic [SW-1:0]   s_cnt, s_cnt_next;
  logic [NW-1:0]   n_cnt, n_cnt_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic [DBIT-1:0] dout_next;
  logic            done_next, ferr_next;
  logic            rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      b_reg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_next;
      s_cnt        <= s_cnt_next;
      n_cnt        <= n_cnt_next;
      b_reg        <= b_next;
      dout         <= dout_next;
      rx_done_tick <= done_next;
      frame_err    <= ferr_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!rx_s) state_next = START;
      START: if (s_tick && s_cnt == S_MID) state_next = rx_s ? IDLE : DATA;
      DATA:  if (s_tick && s_cnt == S_BIT_END && n_cnt == N_LAST) state_next = STOP;
      STOP:  if (s_tick && s_cnt == S_STOP_END) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed here and registered, so they all move on the edge
  // that closes the stop-bit sampling tick cycle.
  always_comb begin
    s_cnt_next = s_cnt;
    n_cnt_next = n_cnt;
    b_next     = b_reg;
    dout_next  = dout;
    done_next  = 1'b0;
    ferr_next  = frame_err;
    case (state)
      IDLE: begin
        if (!rx_s) s_cnt_next = '0;
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == S_MID) begin
            s_cnt_next = '0;
            n_cnt_next = '0;
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == S_BIT_END) begin
            s_cnt_next = '0;
            b_next     = {rx_s, b_reg[DBIT-1:1]};
            if (n_cnt != N_LAST) n_cnt_next = n_cnt + 1'b1;
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == S_STOP_END) begin
            done_next = 1'b1;
            ferr_next = ~rx_s;
            dout_next = b_reg;
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx: frames are compared against the
// words and stop-bit levels the bench itself put on the line.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned wide_pulses = 0;
  logic        prev_done = 1'b0;
  logic [2:0]  tick_div = '0;

  // Each entry: {frame_err, dout}
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Baud generator stand-in with dvsr=4: one tick every 5 clocks.
  always @(posedge clk) begin
    if (tick_div == 3'd4) begin
      tick_div <= '0;
      s_tick   <= 1'b1;
    end else begin
      tick_div <= tick_div + 3'd1;
      s_tick   <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_done_tick) begin
      got_q.push_back({frame_err, dout});
      if (prev_done) wide_pulses++;
    end
    prev_done = rx_done_tick;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_level(input logic lvl, input int cycles);
    rx = lvl;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input bit good_stop, input int bc);
    drive_level(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_level(data[i], bc);
    if (good_stop) begin
      drive_level(1'b1, bc);
    end else begin
      // Low across the stop sample point, then idle high before the next frame.
      drive_level(1'b0, (bc * 3) / 4);
      drive_level(1'b1, bc - (bc * 3) / 4);
    end
    exp_q.push_back({~good_stop, data});
  endtask

  task automatic flush_check(input string tag);
    logic [8:0] e, g;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_dout"}, g[7:0], e[7:0]);
      check({tag, "_ferr"}, g[8], e[8]);
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_width"}, wide_pulses, 0);
  endtask

  initial begin
    logic [7:0] c6;
    logic [7:0] rd;
    bit         good;
    int         bc, gap;

    repeat (5) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_done", rx_done_tick, 0);
    check("rst_ferr", frame_err, 0);
    reset = 1'b1;
    drive_level(1'b1, 40);
    check("idle_no_pulse", got_q.size(), 0);

    send_frame(8'h55, 1'b1, 80);
    drive_level(1'b1, 40);
    flush_check("nominal");
    drive_level(1'b1, 200);
    check("dout_hold", dout, 8'h55);

    send_frame(8'hA3, 1'b1, 80);
    send_frame(8'h0F, 1'b1, 80);
    drive_level(1'b1, 40);
    flush_check("b2b");

    drive_level(1'b0, 30);
    drive_level(1'b1, 100);
    flush_check("glitch");
    send_frame(8'h3C, 1'b1, 80);
    drive_level(1'b1, 40);
    flush_check("after_glitch");

    send_frame(8'hFF, 1'b0, 80);
    drive_level(1'b1, 60);
    send_frame(8'h01, 1'b1, 80);
    drive_level(1'b1, 40);
    flush_check("bad_stop");

    c6 = 8'hC6;
    drive_level(1'b0, 80);
    for (int i = 0; i < 4; i++) drive_level(c6[i], 80);
    drive_level(c6[4], 20);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_dout", dout, 0);
    check("midrst_done", rx_done_tick, 0);
    check("midrst_ferr", frame_err, 0);
    reset = 1'b1;
    drive_level(1'b1, 900);
    flush_check("midrst_nopulse");
    send_frame(8'h81, 1'b1, 80);
    drive_level(1'b1, 40);
    flush_check("after_rst");

    send_frame(8'h96, 1'b1, 78);
    drive_level(1'b1, 40);
    send_frame(8'h96, 1'b1, 82);
    drive_level(1'b1, 40);
    flush_check("margin");

    for (int n = 0; n < 24; n++) begin
      rd   = 8'($urandom);
      good = ($urandom_range(3) != 0);
      bc   = good ? int'($urandom_range(82, 78)) : 80;
      gap  = good ? int'($urandom_range(40)) : int'($urandom_range(100, 60));
      send_frame(rd, good, bc);
      if (gap > 0) drive_level(1'b1, gap);
    end
    drive_level(1'b1, 60);
    flush_check("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
